// File: rtl/altera_up_slow_clock_recovery.sv
// -----------------------------------------------------------------------------
// altera_up_slow_clock_recovery
//
// Receive-side companion to the slow clock generator. Samples an external slow
// serial clock (I2C SCL, audio BCLK/LRCK, PS/2 clock, ...) in the system clock
// domain and rebuilds the generator's strobe set: edge pulses, predicted
// mid-high / mid-low pulses and a clean registered copy of the clock.
//
// The centre of each level is predicted from the length of the previous level
// of the same polarity, so downstream shifters can sample data mid-level.
//
// Parameters
//   CB                    counter width; longest measurable level 2^CB-1 clks
//
// Ports
//   clk                   system clock, rising edge
//   reset                 synchronous, active-high reset
//   serial_clk_in         asynchronous slow clock input
//   new_clk               synchronized, registered copy of serial_clk_in
//   rising_edge           1-cycle pulse on new_clk 0->1
//   falling_edge          1-cycle pulse on new_clk 1->0
//   middle_of_high_level  1-cycle pulse at predicted centre of high level
//   middle_of_low_level   1-cycle pulse at predicted centre of low level
//   locked                both level lengths measured from complete levels
//   timeout               1-cycle stall indication (SLOW_CLK_TIMEOUT_EN only)
//   high_count            last measured high length in clk cycles
//   low_count             last measured low length in clk cycles
//
// Build option
//   SLOW_CLK_TIMEOUT_EN   when defined, a level that saturates the counter
//                         pulses timeout and drops the FSM back to IDLE.
//                         When undefined, timeout is tied low.
// -----------------------------------------------------------------------------
module altera_up_slow_clock_recovery #(
  parameter int CB = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          serial_clk_in,
  output logic          new_clk,
  output logic          rising_edge,
  output logic          falling_edge,
  output logic          middle_of_high_level,
  output logic          middle_of_low_level,
  output logic          locked,
  output logic          timeout,
  output logic [CB-1:0] high_count,
  output logic [CB-1:0] low_count
);

  localparam logic [CB-1:0] CNT_MAX = {CB{1'b1}};
  localparam logic [CB-1:0] MIN_LEN = CB'(4);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SYNC1  = 2'd1;
  localparam logic [1:0] S_SYNC2  = 2'd2;
  localparam logic [1:0] S_LOCKED = 2'd3;

  // Saturating increment; also yields the captured length min(cnt+1, max).
  function automatic logic [CB-1:0] sat_inc(input logic [CB-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + CB'(1);
  endfunction

  logic          meta_q, sync_q, prev_q;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic [CB-1:0] cnt_q, cnt_d;
  logic [CB-1:0] high_q, high_d;
  logic [CB-1:0] low_q, low_d;
  logic [1:0]    state_q, state_d;
  logic          edge_d;
  logic          is_locked;

`ifdef SLOW_CLK_TIMEOUT_EN
  logic          timeout_q, timeout_d;
`endif

  // Edge detection looks one stage ahead (sync vs prev) so that the pulse,
  // the counter restart and the length capture all land in the same cycle
  // that new_clk changes.
  always_comb begin
    rise_d  = sync_q & ~prev_q;
    fall_d  = ~sync_q & prev_q;
    edge_d  = rise_d | fall_d;
    cnt_d   = edge_d ? '0 : sat_inc(cnt_q);
    high_d  = high_q;
    low_d   = low_q;
    state_d = state_q;
`ifdef SLOW_CLK_TIMEOUT_EN
    timeout_d = 1'b0;
`endif
    if (edge_d) begin
      // The level ending at the first edge after IDLE is partial: no capture.
      if (state_q != S_IDLE) begin
        if (fall_d) high_d = sat_inc(cnt_q);
        if (rise_d) low_d  = sat_inc(cnt_q);
      end
      case (state_q)
        S_IDLE:  state_d = S_SYNC1;
        S_SYNC1: state_d = S_SYNC2;
        default: state_d = S_LOCKED;
      endcase
    end
`ifdef SLOW_CLK_TIMEOUT_EN
    // Counter saturated with no edge: the input has stalled. Only fires once
    // because the FSM is then in IDLE while cnt stays saturated.
    else if ((cnt_q == CNT_MAX) && (state_q != S_IDLE)) begin
      timeout_d = 1'b1;
      state_d   = S_IDLE;
    end
`endif
  end

  // Synchronizer, edge pulses, level counter, captured lengths, FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
      high_q  <= '0;
      low_q   <= '0;
      state_q <= S_IDLE;
`ifdef SLOW_CLK_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      meta_q  <= serial_clk_in;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
      high_q  <= high_d;
      low_q   <= low_d;
      state_q <= state_d;
`ifdef SLOW_CLK_TIMEOUT_EN
      timeout_q <= timeout_d;
`endif
    end
  end

  assign is_locked    = (state_q == S_LOCKED);
  assign new_clk      = prev_q;
  assign rising_edge  = rise_q;
  assign falling_edge = fall_q;
  assign locked       = is_locked;
  assign high_count   = high_q;
  assign low_count    = low_q;

  // Mid-level strobes: cnt is 0 in an edge-pulse cycle, so the edge already
  // wins; the explicit mask keeps that priority obvious. Levels shorter than
  // predicted simply truncate without a strobe.
  assign middle_of_high_level = prev_q & is_locked & (high_q >= MIN_LEN) &
                                (cnt_q == (high_q >> 1)) & ~rise_q & ~fall_q;
  assign middle_of_low_level  = ~prev_q & is_locked & (low_q >= MIN_LEN) &
                                (cnt_q == (low_q >> 1)) & ~rise_q & ~fall_q;

`ifdef SLOW_CLK_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule
